// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and sizing helpers for the FIFO stream reader and its skid buffer.
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 3;

    // Wide enough to hold 0..pkt_len.
    function automatic int idx_width(input int pkt_len);
        return $clog2(pkt_len + 1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream, bundled for the reader.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rd_en;
    logic                  rd_val;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output rd_en,
        input  rd_val,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  rd_en,
        output rd_val,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Small shift-down buffer: entry 0 is the head, new words land just above the last valid entry.
module stream_skid_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3,
    parameter int OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [OCC_W-1:0]      occ
);
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem, mem_nxt;
    logic [OCC_W-1:0] occ_nxt, wr_idx;
    logic do_pop;

    assign do_pop = pop && (occ != '0);
    assign head   = mem[0];

    always_comb begin
        mem_nxt = mem;
        occ_nxt = occ;
        wr_idx  = occ;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_nxt[i] = mem[i+1];
            wr_idx  = occ - 1'b1;
            occ_nxt = occ - 1'b1;
        end
        // Simultaneous push/pop writes into the slot the pop just vacated.
        if (push && (int'(wr_idx) < DEPTH)) begin
            mem_nxt[wr_idx] = data_in;
            occ_nxt         = wr_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '0;
            occ <= '0;
        end else begin
            mem <= mem_nxt;
            occ <= occ_nxt;
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO into a packetised valid/ready stream; rd_en never sees out_ready.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    fifo_stream_reader_if.master bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_count
);
    localparam int IW = idx_width(PKT_LEN);
    localparam int OW = $clog2(SKID_DEPTH + 1);
    localparam int SW = OW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

    state_t                state, state_nxt;
    logic [IW-1:0]         req_idx, beat_idx;
    logic [OW-1:0]         occ;
    logic                  inflight, rd_en, out_valid, out_last, accept;
    logic [DATA_WIDTH-1:0] head_data;

    // Credit check counts the word already in flight, so buffer plus FIFO latency never exceeds 3.
    assign rd_en = (state != IDLE) && bus.rd_val
                && ((SW'(occ) + SW'(inflight)) < SW'(SKID_DEPTH))
                && ((state == RUN) || (req_idx != '0));

    assign out_valid     = (occ != '0);
    assign out_last      = out_valid && (beat_idx == LAST_IDX);
    assign accept        = out_valid && bus.out_ready;
    assign busy          = (state != IDLE);
    assign bus.rd_en     = rd_en;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_data  = head_data;

    // Leaving RUN always passes through DRAIN; with req_idx already 0 it just waits for the buffer to empty.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN:   if ((req_idx == '0) && (occ == '0) && !inflight) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_idx   <= '0;
            beat_idx  <= '0;
            inflight  <= 1'b0;
            pkt_count <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_en;
            if (rd_en)
                req_idx <= (req_idx == LAST_IDX) ? '0 : req_idx + 1'b1;
            if (accept)
                beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + 1'b1;
            if (accept && out_last)
                pkt_count <= pkt_count + 1'b1;
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .push    (inflight),
        .data_in (bus.rd_data),
        .pop     (accept),
        .head    (head_data),
        .occ     (occ)
    );

endmodule
